// File: rtl/cp0_pkg.sv
// cp0_pkg -- shared CP0 register numbers, ExcCodes, bit positions and FSM encoding.
// Rev 1.0
`default_nettype none
package cp0_pkg;
   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam int ST_BEV    = 22;
   localparam int ST_IM_LO  = 8;
   localparam int ST_EXL    = 1;
   localparam int ST_IE     = 0;
   localparam int CA_BD     = 31;
   localparam int CA_TI     = 30;
   localparam int CA_IP_LO  = 8;
   localparam int CA_EXC_LO = 2;

   typedef enum logic [1:0] {
      S_RST   = 2'd0,
      S_IDLE  = 2'd1,
      S_REDIR = 2'd2,
      S_DRAIN = 2'd3
   } cp0_state_t;

   localparam logic [31:0] DEF_RESET_VEC = 32'hBFC0_0000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'hBFC0_0380;
endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
// cp0_timer -- Count (half core rate), Compare and the sticky timer-interrupt flag.
// Rev 1.0
`default_nettype none
module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);
   logic        tick;
   logic [31:0] count_inc;

   assign count_inc = count + 32'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= 32'd0;
         compare <= 32'd0;
         tick    <= 1'b0;
         ti      <= 1'b0;
      end else begin
         if (count_we) begin
            count <= wdata;
            tick  <= 1'b0;
         end else begin
            tick <= ~tick;
            if (tick) count <= count_inc;
         end
         // Match is judged on the post-increment value, so a wrap to 0 still hits Compare=0
         if (compare_we) begin
            compare <= wdata;
            ti      <= 1'b0;
         end else if (!count_we && tick && (count_inc == compare)) begin
            ti <= 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl -- WB-stage exception arbiter, CP0 register file and flush/redirect sequencer.
// Rev 1.0
`default_nettype none
module cp0_exc_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
   parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid,
   input  logic [31:0] wb_pc,
   input  logic        wb_bd,
   input  logic        wb_exc,
   input  logic [4:0]  wb_exc_code,
   input  logic [31:0] wb_badvaddr,
   input  logic        wb_eret,
   input  logic        wb_mtc0,
   input  logic [4:0]  wb_cp0_addr,
   input  logic [31:0] wb_cp0_wdata,
   output logic [31:0] cp0_rdata,
   input  logic [5:0]  hw_int,
   output logic        ex_taken,
   output logic [31:0] ex_addr,
   output logic        ex_flush,
   output logic [31:0] cp0_epc,
   output logic        cp0_exl
);
   cp0_state_t  state, state_next;
   logic        ie, exl, bd;
   logic [7:0]  im;
   logic [1:0]  ip_sw;
   logic [4:0]  exc_code;
   logic [31:0] epc, badvaddr, redir_addr;
   logic [31:0] count, compare;
   logic        ti;
   logic [7:0]  ip;
   logic        int_pend, take_int, take_exc, take_entry, take_eret, do_mtc0;
   logic [31:0] status_rd, cause_rd;

   assign ip         = {ti | hw_int[5], hw_int[4:0], ip_sw};
   assign int_pend   = ie & ~exl & (|(ip & im));
   assign take_entry = take_int | take_exc;

   cp0_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (do_mtc0 && (wb_cp0_addr == CP0_COUNT)),
      .compare_we (do_mtc0 && (wb_cp0_addr == CP0_COMPARE)),
      .wdata      (wb_cp0_wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_RST;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      ex_taken   = 1'b0;
      ex_flush   = 1'b0;
      ex_addr    = redir_addr;
      take_int   = 1'b0;
      take_exc   = 1'b0;
      take_eret  = 1'b0;
      do_mtc0    = 1'b0;
      unique case (state)
         S_RST: begin
            ex_taken   = 1'b1;
            ex_flush   = 1'b1;
            ex_addr    = RESET_VEC;
            state_next = S_IDLE;
         end
         S_IDLE: begin
            if (wb_valid) begin
               if (int_pend)     take_int  = 1'b1;
               else if (wb_exc)  take_exc  = 1'b1;
               else if (wb_eret) take_eret = 1'b1;
               else if (wb_mtc0) do_mtc0   = 1'b1;
            end
            if (take_int || take_exc || take_eret) state_next = S_REDIR;
         end
         S_REDIR: begin
            ex_taken   = 1'b1;
            ex_flush   = 1'b1;
            state_next = S_DRAIN;
         end
         S_DRAIN: begin
            ex_flush   = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_RST;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ie         <= 1'b0;
         exl        <= 1'b0;
         im         <= 8'd0;
         bd         <= 1'b0;
         ip_sw      <= 2'd0;
         exc_code   <= 5'd0;
         epc        <= 32'd0;
         badvaddr   <= 32'd0;
         redir_addr <= RESET_VEC;
      end else if (take_entry) begin
         // A nested entry keeps the original return point
         if (!exl) begin
            epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
            bd  <= wb_bd;
         end
         exl        <= 1'b1;
         exc_code   <= take_int ? EXC_INT : wb_exc_code;
         redir_addr <= EXC_VEC;
         if (take_exc && ((wb_exc_code == EXC_ADEL) || (wb_exc_code == EXC_ADES)))
            badvaddr <= wb_badvaddr;
      end else if (take_eret) begin
         exl        <= 1'b0;
         redir_addr <= epc;
      end else if (do_mtc0) begin
         case (wb_cp0_addr)
            CP0_STATUS: begin
               im  <= wb_cp0_wdata[ST_IM_LO +: 8];
               exl <= wb_cp0_wdata[ST_EXL];
               ie  <= wb_cp0_wdata[ST_IE];
            end
            CP0_CAUSE: ip_sw <= wb_cp0_wdata[CA_IP_LO +: 2];
            CP0_EPC:   epc   <= wb_cp0_wdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      status_rd                     = 32'd0;
      status_rd[ST_BEV]             = 1'b1;
      status_rd[ST_IM_LO +: 8]      = im;
      status_rd[ST_EXL]             = exl;
      status_rd[ST_IE]              = ie;
      cause_rd                      = 32'd0;
      cause_rd[CA_BD]               = bd;
      cause_rd[CA_TI]               = ti;
      cause_rd[CA_IP_LO +: 8]       = ip;
      cause_rd[CA_EXC_LO +: 5]      = exc_code;
      case (wb_cp0_addr)
         CP0_BADVADDR: cp0_rdata = badvaddr;
         CP0_COUNT:    cp0_rdata = count;
         CP0_COMPARE:  cp0_rdata = compare;
         CP0_STATUS:   cp0_rdata = status_rd;
         CP0_CAUSE:    cp0_rdata = cause_rd;
         CP0_EPC:      cp0_rdata = epc;
         default:      cp0_rdata = 32'd0;
      endcase
   end

   assign cp0_epc = epc;
   assign cp0_exl = exl;
endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl -- register vectors plus exception/ERET/interrupt/reset sequences.
// Rev 1.0
`default_nettype none
module tb_cp0_exc_ctrl;
   localparam logic [31:0] RVEC = 32'hBFC0_0000;
   localparam logic [31:0] EVEC = 32'hBFC0_0380;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid, wb_bd, wb_exc, wb_eret, wb_mtc0;
   logic [31:0] wb_pc, wb_badvaddr, wb_cp0_wdata;
   logic [4:0]  wb_exc_code, wb_cp0_addr;
   logic [5:0]  hw_int;
   logic [31:0] cp0_rdata, ex_addr, cp0_epc;
   logic        ex_taken, ex_flush, cp0_exl;

   int          errors = 0;
   int          checks = 0;
   logic        mon_en = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] v;

   cp0_exc_ctrl dut (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_bd(wb_bd),
      .wb_exc(wb_exc), .wb_exc_code(wb_exc_code), .wb_badvaddr(wb_badvaddr),
      .wb_eret(wb_eret), .wb_mtc0(wb_mtc0), .wb_cp0_addr(wb_cp0_addr),
      .wb_cp0_wdata(wb_cp0_wdata), .cp0_rdata(cp0_rdata), .hw_int(hw_int),
      .ex_taken(ex_taken), .ex_addr(ex_addr), .ex_flush(ex_flush),
      .cp0_epc(cp0_epc), .cp0_exl(cp0_exl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Redirect scoreboard: every ex_taken pulse must match the oldest expected target
   always @(negedge clk) begin
      #2;
      if (mon_en && ex_taken) begin
         if (exp_q.size() == 0) chk("redir_unexpected", {31'd0, ex_taken}, 32'd0);
         else                   chk("redir_addr", ex_addr, exp_q.pop_front());
      end
   end

   task automatic clr();
      wb_valid = 0; wb_pc = 0; wb_bd = 0; wb_exc = 0; wb_exc_code = 0;
      wb_badvaddr = 0; wb_eret = 0; wb_mtc0 = 0; wb_cp0_addr = 0; wb_cp0_wdata = 0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk); clr();
      wb_valid = 1; wb_mtc0 = 1; wb_cp0_addr = a; wb_cp0_wdata = d;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] val);
      @(negedge clk); clr();
      wb_cp0_addr = a;
      #1 val = cp0_rdata;
   endtask

   task automatic exc(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                      input logic [31:0] bva);
      @(negedge clk); clr();
      wb_valid = 1; wb_exc = 1; wb_pc = pc; wb_bd = bd; wb_exc_code = code; wb_badvaddr = bva;
      exp_q.push_back(EVEC);
   endtask

   task automatic eret(input logic [31:0] tgt);
      @(negedge clk); clr();
      wb_valid = 1; wb_eret = 1;
      exp_q.push_back(tgt);
   endtask

   // Two flush cycles with squashed garbage in WB, then flush must drop
   task automatic drain_check(input string nm);
      @(negedge clk); clr();
      wb_valid = 1; wb_exc = 1; wb_exc_code = 5'd10; wb_pc = 32'h0000_BAD0;
      #1 chk({nm, "_flush1"}, {31'd0, ex_flush}, 32'd1);
      @(negedge clk); clr();
      wb_valid = 1; wb_eret = 1;
      #1 chk({nm, "_flush2"}, {31'd0, ex_flush}, 32'd1);
      chk({nm, "_taken2"}, {31'd0, ex_taken}, 32'd0);
      @(negedge clk); clr();
      #1 chk({nm, "_flush3"}, {31'd0, ex_flush}, 32'd0);
   endtask

   typedef struct {
      string       name;
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{"status_all1", 1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0040_FF03};
      vecs[1] = '{"cause_all1",  1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0000_0300};
      vecs[2] = '{"cause_zero",  1'b1, 5'd13, 32'h0000_0000, 32'h0000_0000};
      vecs[3] = '{"status_zero", 1'b1, 5'd12, 32'h0000_0000, 32'h0040_0000};
      vecs[4] = '{"epc_wr",      1'b1, 5'd14, 32'h1234_5678, 32'h1234_5678};
      vecs[5] = '{"compare_wr",  1'b1, 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[6] = '{"count_wr",    1'b1, 5'd9,  32'h0000_0100, 32'h0000_0100};
      vecs[7] = '{"unimpl_rd",   1'b0, 5'd0,  32'h0,         32'h0};
      vecs[8] = '{"badva_rst",   1'b0, 5'd8,  32'h0,         32'h0};

      reset = 1; hw_int = 0; clr();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_taken", {31'd0, ex_taken}, 32'd1);
      chk("rst_flush", {31'd0, ex_flush}, 32'd1);
      chk("rst_addr",  ex_addr, RVEC);
      chk("rst_exl",   {31'd0, cp0_exl}, 32'd0);
      chk("rst_epc",   cp0_epc, 32'd0);
      @(negedge clk);
      exp_q.push_back(RVEC); mon_en = 1; reset = 0;
      rd(5'd12, v); chk("status_rst", v, 32'h0040_0000);

      foreach (vecs[i]) begin
         if (vecs[i].wr) mtc0(vecs[i].addr, vecs[i].wdata);
         rd(vecs[i].addr, v);
         chk(vecs[i].name, v, vecs[i].exp);
      end

      // Syscall, not in a delay slot
      exc(32'h8000_1000, 1'b0, 5'd8, 32'h0);
      drain_check("sys");
      chk("sys_exl", {31'd0, cp0_exl}, 32'd1);
      chk("sys_epc", cp0_epc, 32'h8000_1000);
      rd(5'd13, v);
      chk("sys_code", {27'd0, v[6:2]}, 32'd8);
      chk("sys_bd",   {31'd0, v[31]}, 32'd0);
      eret(32'h8000_1000);
      drain_check("eret1");
      chk("eret1_exl", {31'd0, cp0_exl}, 32'd0);

      // Delay-slot AdEL, then a nested Bp, then ERET back to the branch
      exc(32'h8000_2004, 1'b1, 5'd4, 32'h0000_0003);
      drain_check("adel");
      chk("adel_epc", cp0_epc, 32'h8000_2000);
      rd(5'd13, v);
      chk("adel_bd",   {31'd0, v[31]}, 32'd1);
      chk("adel_code", {27'd0, v[6:2]}, 32'd4);
      rd(5'd8, v); chk("adel_badva", v, 32'h0000_0003);
      exc(32'h8000_3000, 1'b0, 5'd9, 32'hFFFF_FFFF);
      drain_check("bp");
      chk("bp_epc", cp0_epc, 32'h8000_2000);
      rd(5'd13, v);
      chk("bp_code", {27'd0, v[6:2]}, 32'd9);
      chk("bp_bd",   {31'd0, v[31]}, 32'd1);
      rd(5'd8, v); chk("bp_badva_kept", v, 32'h0000_0003);
      eret(32'h8000_2000);
      drain_check("eret2");
      chk("eret2_exl", {31'd0, cp0_exl}, 32'd0);

      // Count wrap hits Compare=0
      mtc0(5'd11, 32'h0);
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd(5'd9, v);  chk("wrap_count", v, 32'hFFFF_FFFF);
      rd(5'd13, v); chk("wrap_ti_early", {31'd0, v[30]}, 32'd0);
      rd(5'd13, v); chk("wrap_ti", {31'd0, v[30]}, 32'd1);
      mtc0(5'd11, 32'hFFFF_0000);
      rd(5'd13, v); chk("cmp_wr_clears_ti", {31'd0, v[30]}, 32'd0);

      // External interrupt on hw_int[2] via IM bit 12
      mtc0(5'd12, 32'h0000_1001);
      hw_int = 6'b000100;
      rd(5'd13, v); chk("hw_ip", {24'd0, v[15:8]}, 32'h10);
      @(negedge clk); clr();
      wb_valid = 1; wb_pc = 32'h8000_5000;
      exp_q.push_back(EVEC);
      drain_check("hwint");
      hw_int = 0;
      chk("hwint_epc", cp0_epc, 32'h8000_5000);
      rd(5'd13, v); chk("hwint_code", {27'd0, v[6:2]}, 32'd0);
      eret(32'h8000_5000);
      drain_check("eret3");

      // Timer interrupt; the MTC0 Compare riding on the interrupted instruction is dropped
      mtc0(5'd11, 32'd10);
      mtc0(5'd12, 32'h0040_8001);
      mtc0(5'd9, 32'd0);
      v = 0;
      for (int n = 0; n < 60; n++) begin
         rd(5'd13, v);
         if (v[30]) break;
      end
      chk("timer_ti", {31'd0, v[30]}, 32'd1);
      rd(5'd9, v); chk("timer_count", v, 32'd10);
      @(negedge clk); clr();
      wb_valid = 1; wb_pc = 32'h8000_4000; wb_mtc0 = 1; wb_cp0_addr = 5'd11; wb_cp0_wdata = 32'h55;
      exp_q.push_back(EVEC);
      drain_check("tint");
      chk("tint_exl", {31'd0, cp0_exl}, 32'd1);
      chk("tint_epc", cp0_epc, 32'h8000_4000);
      rd(5'd11, v); chk("tint_mtc0_dropped", v, 32'd10);
      rd(5'd13, v); chk("tint_code", {27'd0, v[6:2]}, 32'd0);

      // Reset during REDIR overrides the pending redirect immediately
      exc(32'h8000_6000, 1'b0, 5'd8, 32'h0);
      @(negedge clk); clr();
      #3 mon_en = 0; reset = 1;
      #1;
      chk("rredir_taken", {31'd0, ex_taken}, 32'd1);
      chk("rredir_addr", ex_addr, RVEC);
      chk("rredir_exl", {31'd0, cp0_exl}, 32'd0);
      chk("rredir_epc", cp0_epc, 32'd0);
      repeat (2) @(negedge clk);
      exp_q.push_back(RVEC); mon_en = 1; reset = 0;
      rd(5'd12, v); chk("status_rst2", v, 32'h0040_0000);
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception controller for the five-stage MIPS core. It sits beside the WB stage, where precise exceptions are committed. It arbitrates between reset, interrupts, synchronous exceptions and ERET, and updates the CP0 registers (Status, Cause, EPC, BadVAddr, Count, Compare). It then sequences a one-shot pipeline flush and PC redirect to 0xBFC00000, 0xBFC00380 or EPC.

## Interface
- RESET_VEC, 32'hBFC0_0000: fetch address after reset
- EXC_VEC, 32'hBFC0_0380: general exception entry

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- wb_valid  in  1  WB holds a live instruction
- wb_pc  in  32  PC of WB instruction
- wb_bd  in  1  WB instruction is in a delay slot
- wb_exc  in  1  WB instruction carries a synchronous exception
- wb_exc_code  in  5  ExcCode (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12)
- wb_badvaddr  in  32  faulting address (AdEL/AdES)
- wb_eret  in  1  WB instruction is ERET
- wb_mtc0  in  1  MTC0 commit
- wb_cp0_addr  in  5  CP0 register number for MTC0/MFC0
- wb_cp0_wdata  in  32  MTC0 data
- cp0_rdata  out  32  MFC0 read data (combinational on wb_cp0_addr)
- hw_int  in  6  external interrupt lines, level-sensitive
- ex_taken  out  1  one-cycle redirect pulse
- ex_addr  out  32  redirect target, valid while ex_taken=1
- ex_flush  out  1  flush IF..WB
- cp0_epc  out  32  current EPC
- cp0_exl  out  1  Status.EXL

## Operation
- Registers and their reset values:
  - Status(12) = 0x0040_0000: BEV bit22 is read-only 1; IM[15:8] and EXL bit1 are R/W; IE bit0 is R/W.
  - Cause(13) = 0: BD bit31; TI bit30; IP[15:10] mirror {TI|hw_int[5], hw_int[4:0]}; IP[9:8] are software R/W; ExcCode[6:2].
  - EPC(14), BadVAddr(8), Count(9), Compare(11) all reset to 0.
- Count increments on every second clk, using an internal toggle bit. MTC0 Count loads the value and clears the toggle bit.
- When Count == Compare after an increment, TI is set. MTC0 Compare clears TI.
- int_pend = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM). An interrupt is attached only to a cycle with wb_valid=1.
- Priority in IDLE, highest first:
  1. int_pend: ExcCode=0.
  2. wb_exc: ExcCode=wb_exc_code; BadVAddr=wb_badvaddr when the code is 4 or 5.
  3. wb_eret.
  4. wb_mtc0.
  - A taken exception or interrupt suppresses MTC0 and ERET in the same cycle.
- Exception entry, for both interrupts and synchronous exceptions:
  - If EXL=0: EPC = wb_bd ? wb_pc-4 : wb_pc, and BD = wb_bd.
  - If EXL=1: EPC and BD are unchanged.
  - In both cases EXL is set, ExcCode is written, and the redirect target is EXC_VEC.
- ERET clears EXL and redirects to EPC. The EPC value used is the one before any same-cycle write.
- FSM states:
  - RST: entered on reset. Asserts ex_taken=1, ex_flush=1 and ex_addr=RESET_VEC for one cycle, then goes to IDLE.
  - IDLE: evaluates WB. On exception, interrupt or ERET, updates CP0 at the clock edge and goes to REDIR.
  - REDIR: ex_taken=1, ex_flush=1, ex_addr is the latched target. Goes to DRAIN.
  - DRAIN: ex_flush=1. WB inputs are ignored because they come from squashed instructions. Goes to IDLE.
- Count and Compare keep running in every state. hw_int is sampled in all states, but an interrupt can be taken only in IDLE.

## Timing
- Event seen in WB in cycle N → CP0 registers updated at the end of N → ex_taken and ex_addr in cycle N+1 → ex_flush in N+1 and N+2 → a new WB event is accepted from N+3.
- Outputs during reset: ex_taken=1, ex_flush=1, ex_addr=RESET_VEC, cp0_exl=0, cp0_epc=0.
- MTC0 takes effect at the end of its WB cycle. An MFC0 in the next cycle returns the new value.
- Reset asserted in any state forces RST asynchronously; any pending redirect is discarded.
- Count wraps from 0xFFFFFFFF to 0. A Compare match at the wrap still sets TI.

## Structure
- Package cp0_pkg holds:
  - CP0 register numbers.
  - ExcCode constants.
  - Status and Cause bit positions.
  - FSM state encoding (RST, IDLE, REDIR, DRAIN).
  - RESET_VEC and EXC_VEC defaults.
- One sub-module, cp0_timer, contains Count, Compare, the toggle bit and TI generation.
- The FSM, priority logic and the other registers stay in cp0_exc_ctrl.

## Test plan
- Reset release: cycle 0 after reset gives ex_taken=1, ex_addr=0xBFC00000; Status reads 0x00400000.
- Syscall: wb_exc=1, code=8, wb_pc=0x80001000, wb_bd=0 → next cycle ex_addr=0xBFC00380; EPC=0x80001000; Cause[6:2]=8; EXL=1; flush lasts 2 cycles.
- Delay-slot AdEL: wb_pc=0x80002004, wb_bd=1, badvaddr=0x3 → EPC=0x80002000, Cause.BD=1, BadVAddr=0x3. Then ERET → ex_addr=0x80002000 and EXL=0.
- Timer interrupt: Compare=10, Count=0, Status=0x00408001 → after about 20 cycles TI=1. On the next valid WB instruction the interrupt is taken with ExcCode=0 and any MTC0 in that cycle is suppressed.
- Nested exception: with EXL=1, a Bp exception at pc 0x80003000 → EPC is unchanged, ExcCode=9, redirect to 0xBFC00380.
- Reset asserted during REDIR → ex_taken is held and ex_addr becomes 0xBFC00000 immediately.
